// File: rtl/sdi_cfg_multi.sv
// Per-channel SDI configuration block: geometry shadow/active registers, frame-synchronous commit,
// camera reset pulse, registered read port. Optional link-loss interrupt under SDI_CFG_LINK_IRQ_EN.
module sdi_cfg_multi #(
   parameter int unsigned CFG_DATA_WIDTH = 32,
   parameter int unsigned CFG_ADDR_WIDTH = 32,
   parameter int unsigned CH_NUM         = 4,
   parameter int unsigned RST_LEN        = 8
) (
   input  logic                      i_cfg_clk,
   input  logic                      i_cfg_rst_n,
   input  logic                      s_cfg_wr_en,
   input  logic [CFG_DATA_WIDTH-1:0] s_cfg_wr_data,
   input  logic [CFG_ADDR_WIDTH-1:0] s_cfg_addr,
   input  logic                      s_cfg_rd_en,
   output logic                      s_cfg_rd_vld,
   output logic [CFG_DATA_WIDTH-1:0] s_cfg_rd_data,
   output logic                      s_cfg_busy,
   input  logic [CH_NUM-1:0]         i_linkup,
   input  logic [CH_NUM-1:0]         i_frame_start,
   output logic [CH_NUM-1:0]         o_cmr_rst,
   output logic [CH_NUM-1:0]         o_cmr_vld,
   output logic [CH_NUM*16-1:0]      o_image_w,
   output logic [CH_NUM*16-1:0]      o_image_h,
   output logic [CH_NUM*16-1:0]      o_offset_x,
   output logic [CH_NUM*16-1:0]      o_offset_y,
   output logic                      o_irq
);

   localparam logic [2:0] RegCtrl   = 3'd0;
   localparam logic [2:0] RegStatus = 3'd1;
   localparam logic [2:0] RegWidth  = 3'd2;
   localparam logic [2:0] RegHeight = 3'd3;
   localparam logic [2:0] RegOffX   = 3'd4;
   localparam logic [2:0] RegOffY   = 3'd5;
   localparam logic [7:0] RstLenCnt = 8'(RST_LEN);

   // Geometry index 0..3 = width, height, offset x, offset y
   logic [CH_NUM-1:0][3:0][15:0] shd_q, shd_d;
   logic [CH_NUM-1:0][3:0][15:0] act_q, act_d;
   logic [CH_NUM-1:0][7:0]       cnt_q, cnt_d;
   logic [CH_NUM-1:0]            vld_q, vld_d;
   logic [CH_NUM-1:0]            pend_q, pend_d;
   logic                         rd_vld_q;
   logic [CFG_DATA_WIDTH-1:0]    rd_data_q;
   logic [CFG_DATA_WIDTH-1:0]    rd_val;

   logic [1:0]        ch_idx;
   logic [2:0]        reg_idx;
   logic [1:0]        geo_idx;
   logic              addr_hit;
   logic              is_geo;
   logic [CH_NUM-1:0] ch_sel;
   logic [CH_NUM-1:0] ch_wr;
   logic [CH_NUM-1:0] ctrl_wr;
   logic [CH_NUM-1:0] commit;
   logic [CH_NUM-1:0] lost_rd;
   logic              unused_bits;

   assign ch_idx   = s_cfg_addr[9:8];
   assign reg_idx  = s_cfg_addr[4:2];
   assign geo_idx  = 2'(reg_idx - RegWidth);
   assign is_geo   = (reg_idx >= RegWidth) && (reg_idx <= RegOffY);
   assign addr_hit = (s_cfg_addr[7:5] == 3'd0) && (32'(ch_idx) < CH_NUM);

   always_comb begin
      ch_sel = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         ch_sel[c] = addr_hit && (ch_idx == 2'(c));
      end
   end

   assign ch_wr   = ch_sel & {CH_NUM{s_cfg_wr_en}};
   assign ctrl_wr = ch_wr & {CH_NUM{reg_idx == RegCtrl}};
   assign commit  = ctrl_wr & {CH_NUM{s_cfg_wr_data[2]}};

   // Commit timing follows the VLD value carried by the same CTRL write
   always_comb begin
      shd_d  = shd_q;
      act_d  = act_q;
      cnt_d  = cnt_q;
      vld_d  = vld_q;
      pend_d = pend_q;
      for (int c = 0; c < CH_NUM; c++) begin
         if (ctrl_wr[c]) begin
            vld_d[c] = s_cfg_wr_data[1];
         end
         if (ctrl_wr[c] && s_cfg_wr_data[0]) begin
            cnt_d[c] = RstLenCnt;
         end else if (cnt_q[c] != 8'd0) begin
            cnt_d[c] = cnt_q[c] - 8'd1;
         end
         if (commit[c] && s_cfg_wr_data[1]) begin
            pend_d[c] = 1'b1;
         end else if (commit[c] || (pend_q[c] && i_frame_start[c])) begin
            pend_d[c] = 1'b0;
         end
         if ((commit[c] && !s_cfg_wr_data[1]) || (pend_q[c] && i_frame_start[c])) begin
            act_d[c] = shd_q[c];
         end
         // Shadow is frozen while a commit waits so the applied frame is never torn
         if (ch_wr[c] && is_geo && !pend_q[c]) begin
            shd_d[c][geo_idx] = s_cfg_wr_data[15:0];
         end
      end
   end

   always_ff @(posedge i_cfg_clk) begin
      if (!i_cfg_rst_n) begin
         shd_q  <= '0;
         act_q  <= '0;
         cnt_q  <= '0;
         vld_q  <= '0;
         pend_q <= '0;
      end else begin
         shd_q  <= shd_d;
         act_q  <= act_d;
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
         pend_q <= pend_d;
      end
   end

`ifdef SDI_CFG_LINK_IRQ_EN
   logic [CH_NUM-1:0] link_q;
   logic [CH_NUM-1:0] lost_q, lost_d;
   logic [CH_NUM-1:0] stat_wr;
   logic              irq_q;

   assign stat_wr = ch_wr & {CH_NUM{reg_idx == RegStatus}};

   // A falling link edge wins over a simultaneous write-1-to-clear
   always_comb begin
      lost_d = lost_q;
      for (int c = 0; c < CH_NUM; c++) begin
         if (link_q[c] && !i_linkup[c]) begin
            lost_d[c] = 1'b1;
         end else if (stat_wr[c] && s_cfg_wr_data[1]) begin
            lost_d[c] = 1'b0;
         end
      end
   end

   always_ff @(posedge i_cfg_clk) begin
      if (!i_cfg_rst_n) begin
         link_q <= '0;
         lost_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         link_q <= i_linkup;
         lost_q <= lost_d;
         irq_q  <= |lost_d;
      end
   end

   assign lost_rd = lost_q;
   assign o_irq   = irq_q;
`else
   assign lost_rd = '0;
   assign o_irq   = 1'b0;
`endif

   always_comb begin
      rd_val = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         if (ch_sel[c]) begin
            case (reg_idx)
               RegCtrl:   rd_val[2:0] = {pend_q[c], vld_q[c], 1'b0};
               RegStatus: rd_val[2:0] = {pend_q[c], lost_rd[c], i_linkup[c]};
               RegWidth, RegHeight, RegOffX, RegOffY: rd_val[15:0] = shd_q[c][geo_idx];
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge i_cfg_clk) begin
      if (!i_cfg_rst_n) begin
         rd_vld_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_vld_q <= s_cfg_rd_en;
         if (s_cfg_rd_en) begin
            rd_data_q <= rd_val;
         end
      end
   end

   assign s_cfg_rd_vld  = rd_vld_q;
   assign s_cfg_rd_data = rd_data_q;
   assign s_cfg_busy    = |pend_q;
   assign o_cmr_vld     = vld_q;

   for (genvar c = 0; c < CH_NUM; c++) begin : g_out
      assign o_cmr_rst[c]          = cnt_q[c] != 8'd0;
      assign o_image_w[16*c +: 16]  = act_q[c][0];
      assign o_image_h[16*c +: 16]  = act_q[c][1];
      assign o_offset_x[16*c +: 16] = act_q[c][2];
      assign o_offset_y[16*c +: 16] = act_q[c][3];
   end

   assign unused_bits = ^{s_cfg_wr_data, s_cfg_addr};

endmodule

// File: tb/tb_sdi_cfg_multi.sv
// Directed bench for sdi_cfg_multi: commit paths, reset pulse, read port, link loss, reset abort.
module tb_sdi_cfg_multi;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en, rd_en;
   logic [31:0] wdata, addr;
   logic [3:0]  linkup, fs;

   logic        rd_vld, busy, irq;
   logic [31:0] rd_data;
   logic [3:0]  cmr_rst, cmr_vld;
   logic [63:0] img_w, img_h, off_x, off_y;

   logic        rd_vld3, busy3, irq3;
   logic [31:0] rd_data3;
   logic [2:0]  cmr_rst3, cmr_vld3;
   logic [47:0] img_w3, img_h3, off_x3, off_y3;

   int n_chk = 0;
   int n_pass = 0;
   int n;

   always #5 clk = ~clk;

   sdi_cfg_multi #(
      .CFG_DATA_WIDTH(32), .CFG_ADDR_WIDTH(32), .CH_NUM(4), .RST_LEN(8)
   ) u_dut (
      .i_cfg_clk(clk), .i_cfg_rst_n(rst_n),
      .s_cfg_wr_en(wr_en), .s_cfg_wr_data(wdata), .s_cfg_addr(addr), .s_cfg_rd_en(rd_en),
      .s_cfg_rd_vld(rd_vld), .s_cfg_rd_data(rd_data), .s_cfg_busy(busy),
      .i_linkup(linkup), .i_frame_start(fs),
      .o_cmr_rst(cmr_rst), .o_cmr_vld(cmr_vld),
      .o_image_w(img_w), .o_image_h(img_h), .o_offset_x(off_x), .o_offset_y(off_y),
      .o_irq(irq)
   );

   // Three-channel instance to exercise channel indices beyond CH_NUM
   sdi_cfg_multi #(
      .CFG_DATA_WIDTH(32), .CFG_ADDR_WIDTH(32), .CH_NUM(3), .RST_LEN(8)
   ) u_dut_ch3 (
      .i_cfg_clk(clk), .i_cfg_rst_n(rst_n),
      .s_cfg_wr_en(wr_en), .s_cfg_wr_data(wdata), .s_cfg_addr(addr), .s_cfg_rd_en(rd_en),
      .s_cfg_rd_vld(rd_vld3), .s_cfg_rd_data(rd_data3), .s_cfg_busy(busy3),
      .i_linkup(linkup[2:0]), .i_frame_start(fs[2:0]),
      .o_cmr_rst(cmr_rst3), .o_cmr_vld(cmr_vld3),
      .o_image_w(img_w3), .o_image_h(img_h3), .o_offset_x(off_x3), .o_offset_y(off_y3),
      .o_irq(irq3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] adr(input int ch, input int rg);
      return 32'((ch << 8) | (rg << 2));
   endfunction

   task automatic wr(input int ch, input int rg, input logic [31:0] d);
      addr  = adr(ch, rg);
      wdata = d;
      wr_en = 1'b1;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic rd(input int ch, input int rg);
      addr  = adr(ch, rg);
      rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n  = 1'b0;
      wr_en  = 1'b0;
      rd_en  = 1'b0;
      wdata  = '0;
      addr   = '0;
      linkup = 4'hF;
      fs     = 4'h0;
      cyc();
      cyc();
      check("reset_rd_vld", 32'(rd_vld), 32'd0);
      check("reset_rd_data", rd_data, 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_cmr", {24'd0, cmr_rst, cmr_vld}, 32'd0);
      check("reset_irq", 32'(irq), 32'd0);
      rst_n = 1'b1;
      cyc();

      // Immediate commit with VLD=0
      wr(1, 2, 32'd1920);
      check("w_shadow_only", 32'(img_w[31:16]), 32'd0);
      wr(1, 0, 32'h4);
      check("w_commit_now", 32'(img_w[31:16]), 32'd1920);
      check("w_commit_busy", 32'(busy), 32'd0);
      rd(1, 2);
      check("w_readback", rd_data, 32'd1920);

      // Frame-synchronous commit with VLD=1
      wr(0, 0, 32'h2);
      check("vld_ch0", 32'(cmr_vld), 32'h1);
      wr(0, 3, 32'd1080);
      wr(0, 0, 32'h6);
      check("h_pending_busy", 32'(busy), 32'd1);
      check("h_pending_out", 32'(img_h[15:0]), 32'd0);
      rd(0, 0);
      check("h_ctrl_read", rd_data, 32'h6);
      wr(0, 3, 32'd720);
      rd(0, 3);
      check("h_write_ignored", rd_data, 32'd1080);
      cyc();
      check("h_still_held", 32'(img_h[15:0]), 32'd0);
      fs = 4'h1;
      cyc();
      fs = 4'h0;
      check("h_applied", 32'(img_h[15:0]), 32'd1080);
      check("h_busy_clear", 32'(busy), 32'd0);

      // COMMIT coincident with frame start waits for the next one
      wr(0, 3, 32'd500);
      fs = 4'h1;
      wr(0, 0, 32'h6);
      fs = 4'h0;
      check("coinc_busy", 32'(busy), 32'd1);
      check("coinc_held", 32'(img_h[15:0]), 32'd1080);
      cyc();
      fs = 4'h1;
      cyc();
      fs = 4'h0;
      check("coinc_applied", 32'(img_h[15:0]), 32'd500);
      check("coinc_busy_clear", 32'(busy), 32'd0);

      // Camera reset pulse length and restart
      wr(2, 0, 32'h1);
      check("rst_start", 32'(cmr_rst[2]), 32'd1);
      n = 0;
      for (int i = 0; i < 64 && cmr_rst[2]; i++) begin
         n++;
         cyc();
      end
      check("rst_len8", 32'(n), 32'd8);
      wr(2, 0, 32'h1);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (cmr_rst[2]) n++;
         cyc();
      end
      if (cmr_rst[2]) n++;
      wr(2, 0, 32'h1);
      for (int i = 0; i < 64 && cmr_rst[2]; i++) begin
         n++;
         cyc();
      end
      check("rst_len13", 32'(n), 32'd13);

      // VLD and RST from one CTRL write
      wr(3, 0, 32'h3);
      check("ctrl_both_rst", 32'(cmr_rst), 32'h8);
      check("ctrl_both_vld", 32'(cmr_vld), 32'h9);

      // Read port
      wr(3, 4, 32'h0100);
      rd(3, 4);
      check("rd_vld", 32'(rd_vld), 32'd1);
      check("rd_offx", rd_data, 32'h100);
      check("rd_ch3_oob", rd_data3, 32'd0);
      cyc();
      check("rd_vld_drop", 32'(rd_vld), 32'd0);
      check("rd_hold", rd_data, 32'h100);
      rd(3, 6);
      check("rd_reg6", rd_data, 32'd0);
      addr  = adr(3, 4) | 32'h20;
      rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
      check("rd_hi_bits", rd_data, 32'd0);
      wr(3, 5, 32'h11);
      addr  = adr(3, 5);
      wdata = 32'h22;
      wr_en = 1'b1;
      rd_en = 1'b1;
      cyc();
      wr_en = 1'b0;
      rd_en = 1'b0;
      check("rd_pre_write", rd_data, 32'h11);
      rd(3, 5);
      check("rd_post_write", rd_data, 32'h22);

      // Link status and interrupt
      rd(1, 1);
      check("stat_link_up", rd_data, 32'h1);
      linkup[1] = 1'b0;
      cyc();
`ifdef SDI_CFG_LINK_IRQ_EN
      check("irq_set", 32'(irq), 32'd1);
      rd(1, 1);
      check("stat_lost", rd_data, 32'h2);
      wr(1, 1, 32'h2);
      check("irq_clear", 32'(irq), 32'd0);
      rd(1, 1);
      check("stat_cleared", rd_data, 32'h0);
`else
      check("irq_tied", 32'(irq), 32'd0);
      rd(1, 1);
      check("stat_no_lost", rd_data, 32'h0);
`endif

      // Reset during a camera pulse with a commit pending
      wr(2, 0, 32'h1);
      wr(0, 0, 32'h6);
      rd(3, 4);
      check("pre_rst_busy", 32'(busy), 32'd1);
      check("pre_rst_pulse", 32'(cmr_rst[2]), 32'd1);
      rst_n = 1'b0;
      cyc();
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_cmr", {24'd0, cmr_rst, cmr_vld}, 32'd0);
      check("abort_geo", {28'd0, |img_w, |img_h, |off_x, |off_y}, 32'd0);
      check("abort_rd", {rd_data[30:0], rd_vld}, 32'd0);
      check("abort_irq", 32'(irq), 32'd0);
      rst_n = 1'b1;
      cyc();
      rd(0, 0);
      check("abort_ctrl", rd_data, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sdi_cfg_multi.md
SDI_CFG_MULTI -- requirements
Module: sdi_cfg_multi

Interface
REQ-001 SHALL have parameter CFG_DATA_WIDTH, default 32: config data bus width; only 32 is supported.
REQ-002 SHALL have parameter CFG_ADDR_WIDTH, default 32: config byte-address width; must be at least 10.
REQ-003 SHALL have parameter CH_NUM, default 4: number of SDI channels, legal range 1..4.
REQ-004 SHALL have parameter RST_LEN, default 8: camera reset pulse length in clocks, legal range 1..255.
REQ-005 SHALL have port i_cfg_clk, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port i_cfg_rst_n, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have ports s_cfg_wr_en, input, 1 and s_cfg_wr_data, input, CFG_DATA_WIDTH: register write strobe and write data.
REQ-008 SHALL have ports s_cfg_addr, input, CFG_ADDR_WIDTH and s_cfg_rd_en, input, 1: byte address and read strobe.
REQ-009 SHALL have ports s_cfg_rd_vld, output, 1 and s_cfg_rd_data, output, CFG_DATA_WIDTH: read-data valid and read data.
REQ-010 SHALL have port s_cfg_busy, output, 1: OR of all channels' commit-pending flags.
REQ-011 SHALL have port i_linkup, input, CH_NUM: live link status, one bit per channel.
REQ-012 SHALL have port i_frame_start, input, CH_NUM: single-cycle start-of-frame pulse, one per channel.
REQ-013 SHALL have ports o_cmr_rst, output, CH_NUM and o_cmr_vld, output, CH_NUM: per-channel camera reset and enable.
REQ-014 SHALL have ports o_image_w, o_image_h, o_offset_x, o_offset_y, each output, CH_NUM*16: active geometry; channel n occupies bits [16n+15:16n].
REQ-015 SHALL have port o_irq, output, 1: level interrupt.

Function
REQ-016 SHALL decode the channel from addr[9:8] and the register from addr[4:2]; addr[7:5] SHALL be nonzero for no mapped register.
REQ-017 SHALL map registers as: 0 CTRL (bit0 RST write-1 pulse, bit1 VLD, bit2 COMMIT write-1), 1 STATUS, 2 WIDTH, 3 HEIGHT, 4 OFFX, 5 OFFY (geometry registers use bits [15:0]).
REQ-018 SHALL treat writes to an unmapped address, or to a channel >= CH_NUM, as having no effect.
REQ-019 SHALL direct geometry writes to per-channel shadow registers; reads of WIDTH..OFFY SHALL return the shadow value.
REQ-020 SHALL, when VLD=0, copy shadow to active geometry on the cycle after a COMMIT write.
REQ-021 SHALL, when VLD=1, set commit_pending on a COMMIT write and copy shadow to active on the cycle after the next i_frame_start of that channel.
REQ-022 SHALL clear commit_pending in the same cycle the copy to active geometry occurs.
REQ-023 SHALL ignore geometry writes to a channel while its commit_pending=1, so that a committed frame is never torn.
REQ-024 SHALL treat a COMMIT written together with an i_frame_start in the same cycle as pending, applying it at the following frame start.
REQ-025 SHALL, on RST=1 written, drive o_cmr_rst[ch] high starting the next cycle for exactly RST_LEN cycles; a rewrite during the pulse SHALL restart the count.
REQ-026 SHALL apply VLD and RST from the same CTRL write independently.
REQ-027 SHALL return a read with s_cfg_rd_vld high exactly 1 cycle after s_cfg_rd_en; s_cfg_rd_data is registered and holds its value until the next read.
REQ-028 SHALL return 0 for reads of unmapped addresses or of channels >= CH_NUM.
REQ-029 SHALL return pre-write data when a read and a write to the same register occur in the same cycle.
REQ-030 SHALL return CTRL reads as {29'd0, commit_pending, VLD, 1'b0}.

Reset
REQ-031 SHALL, while i_cfg_rst_n=0 at a clock edge, clear all shadow and active geometry, VLD, commit_pending, reset counters, the sticky flags, s_cfg_rd_vld and s_cfg_rd_data to 0.
REQ-032 SHALL abort an in-progress o_cmr_rst pulse and any pending commit on reset; all outputs SHALL be 0 in the cycle after reset.

Configuration
REQ-033 SHALL, with SDI_CFG_LINK_IRQ_EN defined, give STATUS as bit0 live linkup, bit1 LOST sticky, bit2 commit_pending.
REQ-034 SHALL, with SDI_CFG_LINK_IRQ_EN defined, set LOST on a 1->0 transition of i_linkup[ch] and clear it by writing 1 to STATUS bit1 (write-1-to-clear).
REQ-035 SHALL, with SDI_CFG_LINK_IRQ_EN defined, drive o_irq registered as the OR of LOST over all channels, and let a set event win over a simultaneous clear.
REQ-036 SHALL, without SDI_CFG_LINK_IRQ_EN, read STATUS bit1 as 0, keep no edge detector, and tie o_irq to 0.

Verification
REQ-037 SHALL verify: VLD=0, write ch1 WIDTH=1920 and then COMMIT -> o_image_w[31:16]=1920 one cycle after the COMMIT.
REQ-038 SHALL verify: ch0 VLD=1, HEIGHT=1080 then COMMIT -> busy=1 and output unchanged; a later HEIGHT=720 write is ignored; after i_frame_start[0] -> output=1080, busy=0.
REQ-039 SHALL verify: RST_LEN=8, write CTRL=1 on ch2 -> 8-cycle pulse; a rewrite at cycle 5 -> pulse totals 13 cycles.
REQ-040 SHALL verify: read ch3 OFFX=0x0100 -> rd_vld and data=0x100 one cycle later; a read of a ch>=CH_NUM or of reg 6 -> 0.
REQ-041 SHALL verify: with the macro defined, drop i_linkup[1] -> LOST=1 and o_irq=1; write STATUS=0x2 -> o_irq=0.
REQ-042 SHALL verify: assert reset mid-pulse with a pending commit -> all outputs 0 and busy=0 in the next cycle.
